// File: rtl/irq_ctl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctl_pkg
// Shared constants for the mips789 interrupt controller:
//   - pc_gen pre-control codes (PC_IGN / PC_IRQ / PC_RST)
//   - configuration register addresses (IRQ_CTRL/MASK/PEND/VBASE)
//   - controller FSM state encodings (IRQ_S_*)
//   - priority pick helper (lowest index wins) and state -> pre-control decode
// -----------------------------------------------------------------------------
package irq_ctl_pkg;

  localparam int NIRQ  = 4;
  localparam int IDX_W = 2;

  // pc_gen pre-control codes
  localparam logic [3:0] PC_IGN = 4'd0;
  localparam logic [3:0] PC_IRQ = 4'd2;
  localparam logic [3:0] PC_RST = 4'd3;

  // Configuration register addresses
  localparam logic [1:0] IRQ_CTRL  = 2'd0;
  localparam logic [1:0] IRQ_MASK  = 2'd1;
  localparam logic [1:0] IRQ_PEND  = 2'd2;
  localparam logic [1:0] IRQ_VBASE = 2'd3;

  // FSM state encodings
  localparam logic [1:0] IRQ_S_RST  = 2'd0;
  localparam logic [1:0] IRQ_S_IDLE = 2'd1;
  localparam logic [1:0] IRQ_S_TAKE = 2'd2;
  localparam logic [1:0] IRQ_S_SERV = 2'd3;

  // VBASE keeps only bits [31:6]; vectors are 16 bytes apart inside that block
  localparam logic [31:0] VBASE_KEEP = 32'hFFFF_FFC0;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } irq_sel_t;

  // Lowest set index wins: scan from the top so the lowest hit is written last.
  function automatic irq_sel_t irq_pick(input logic [NIRQ-1:0] elig);
    irq_sel_t sel;
    sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel.hit = 1'b1;
        sel.idx = IDX_W'(i);
      end
    end
    return sel;
  endfunction

  function automatic logic [3:0] irq_prectl(input logic [1:0] st);
    case (st)
      IRQ_S_RST:  return PC_RST;
      IRQ_S_TAKE: return PC_IRQ;
      default:    return PC_IGN;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// One request line: 2-FF synchroniser followed by an edge-detect stage.
// Ports:
//   i_clock  core clock
//   i_rst_n  asynchronous active-low reset
//   i_pause  pipeline stall; freezes only the edge-detect stage
//   i_req    asynchronous request input
//   o_rise   rising edge seen on the synchronised request
// -----------------------------------------------------------------------------
module irq_sync (
  input  logic i_clock,
  input  logic i_rst_n,
  input  logic i_pause,
  input  logic i_req,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // The synchroniser keeps running during a stall, but the edge-detect stage
  // holds, so an edge arriving while paused stays visible until the first
  // non-paused edge and is not dropped.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_req;
      r_s2 <= r_s1;
      if (!i_pause) begin
        r_s3 <= r_s2;
      end
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_ctl.sv
// -----------------------------------------------------------------------------
// irq_ctl
// Interrupt controller, responder side of the pc_gen pre-control interface.
// Latches four request lines, arbitrates against MASK and the global enable,
// drives the pre-control code and vector address, saves the resume PC and
// reopens interrupts on a return.
// Ports:
//   i_clock, i_rst_n      core clock, asynchronous active-low reset
//   i_pause               pipeline stall: all state and outputs hold
//   i_irq_req[3:0]        asynchronous request lines (rising edge requests)
//   i_cur_pc[31:0]        PC of the next instruction (resume PC on take)
//   i_ret                 return instruction decoded (one-cycle pulse)
//   i_cfg_we/addr/wdata   configuration write port
//   o_cfg_rdata[31:0]     combinational read of register at i_cfg_addr
//   o_pc_prectl[3:0]      PC_RST / PC_IGN / PC_IRQ to pc_gen
//   o_irq_addr[31:0]      vector address to pc_gen
//   o_zz_spc[31:0]        saved return PC to pc_gen
//   o_irq_ack[3:0]        one-hot, high while PC_IRQ is driven
// -----------------------------------------------------------------------------
module irq_ctl
  import irq_ctl_pkg::*;
(
  input  logic            i_clock,
  input  logic            i_rst_n,
  input  logic            i_pause,
  input  logic [NIRQ-1:0] i_irq_req,
  input  logic [31:0]     i_cur_pc,
  input  logic            i_ret,
  input  logic            i_cfg_we,
  input  logic [1:0]      i_cfg_addr,
  input  logic [31:0]     i_cfg_wdata,
  output logic [31:0]     o_cfg_rdata,
  output logic [3:0]      o_pc_prectl,
  output logic [31:0]     o_irq_addr,
  output logic [31:0]     o_zz_spc,
  output logic [NIRQ-1:0] o_irq_ack
);

  logic [1:0]      r_state;
  logic [3:0]      r_prectl;
  logic [31:0]     r_irq_addr;
  logic [31:0]     r_zz_spc;
  logic [NIRQ-1:0] r_irq_ack;
  logic            r_ien;
  logic [NIRQ-1:0] r_mask;
  logic [NIRQ-1:0] r_pend;
  logic [31:0]     r_vbase;

  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_elig;
  irq_sel_t        w_sel;
  logic [NIRQ-1:0] w_sel_onehot;
  logic            w_wr_ctrl;
  logic            w_wr_mask;
  logic            w_wr_vbase;
  logic [NIRQ-1:0] w_w1c;
  logic [NIRQ-1:0] w_ack_clr;
  logic [NIRQ-1:0] w_pend_next;
  logic [1:0]      w_state_next;
  logic            w_ien_next;

  genvar gi;
  generate
    for (gi = 0; gi < NIRQ; gi++) begin : g_sync
      irq_sync u_sync (
        .i_clock (i_clock),
        .i_rst_n (i_rst_n),
        .i_pause (i_pause),
        .i_req   (i_irq_req[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  assign w_wr_ctrl  = i_cfg_we && (i_cfg_addr == IRQ_CTRL);
  assign w_wr_mask  = i_cfg_we && (i_cfg_addr == IRQ_MASK);
  assign w_wr_vbase = i_cfg_we && (i_cfg_addr == IRQ_VBASE);
  assign w_w1c      = (i_cfg_we && (i_cfg_addr == IRQ_PEND)) ? i_cfg_wdata[NIRQ-1:0] : '0;

  assign w_elig       = r_pend & r_mask & {NIRQ{r_ien}};
  assign w_sel        = irq_pick(w_elig);
  assign w_sel_onehot = {{(NIRQ-1){1'b0}}, 1'b1} << w_sel.idx;

  // r_irq_ack holds the one-hot of the line being taken, so it doubles as the
  // pending-bit clear mask when TAKE completes.
  assign w_ack_clr = (r_state == IRQ_S_TAKE) ? r_irq_ack : '0;

  // A new edge overrides both the software clear and the ack clear.
  assign w_pend_next = (r_pend & ~w_w1c & ~w_ack_clr) | w_rise;

  // Enable update order: software write, then the hardware clear on take,
  // then the reopen on return.
  always_comb begin
    w_state_next = r_state;
    w_ien_next   = r_ien;
    if (w_wr_ctrl) begin
      w_ien_next = i_cfg_wdata[0];
    end
    case (r_state)
      IRQ_S_RST:  w_state_next = IRQ_S_IDLE;
      IRQ_S_IDLE: begin
        if (w_sel.hit) begin
          w_state_next = IRQ_S_TAKE;
        end
      end
      IRQ_S_TAKE: begin
        w_state_next = IRQ_S_SERV;
        w_ien_next   = 1'b0;
      end
      IRQ_S_SERV: begin
        if (i_ret) begin
          w_state_next = IRQ_S_IDLE;
          w_ien_next   = 1'b1;
        end
      end
      default:    w_state_next = IRQ_S_RST;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IRQ_S_RST;
      r_prectl   <= PC_RST;
      r_irq_addr <= '0;
      r_zz_spc   <= '0;
      r_irq_ack  <= '0;
      r_ien      <= 1'b0;
      r_mask     <= '0;
      r_pend     <= '0;
      r_vbase    <= '0;
    end else if (!i_pause) begin
      r_state  <= w_state_next;
      r_prectl <= irq_prectl(w_state_next);
      r_ien    <= w_ien_next;
      r_pend   <= w_pend_next;
      if (w_wr_mask) begin
        r_mask <= i_cfg_wdata[NIRQ-1:0];
      end
      if (w_wr_vbase) begin
        r_vbase <= i_cfg_wdata & VBASE_KEEP;
      end
      if ((r_state == IRQ_S_IDLE) && w_sel.hit) begin
        // Vector is fixed on entry to TAKE, from the VBASE value of that cycle.
        r_irq_addr <= {r_vbase[31:6], w_sel.idx, 4'b0000};
        r_irq_ack  <= w_sel_onehot;
      end else if (r_state == IRQ_S_TAKE) begin
        r_zz_spc  <= i_cur_pc;
        r_irq_ack <= '0;
      end
    end
  end

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      IRQ_CTRL:  o_cfg_rdata[0]        = r_ien;
      IRQ_MASK:  o_cfg_rdata[NIRQ-1:0] = r_mask;
      IRQ_PEND:  o_cfg_rdata[NIRQ-1:0] = r_pend;
      IRQ_VBASE: o_cfg_rdata           = r_vbase;
      default:   o_cfg_rdata           = '0;
    endcase
  end

  assign o_pc_prectl = r_prectl;
  assign o_irq_addr  = r_irq_addr;
  assign o_zz_spc    = r_zz_spc;
  assign o_irq_ack   = r_irq_ack;

endmodule

// File: tb/tb_irq_ctl.sv
module tb_irq_ctl;
  import irq_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] cur_pc = 32'h0;
  logic        ret = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  caddr = 2'd0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] o_cfg_rdata;
  logic [3:0]  o_pc_prectl;
  logic [31:0] o_irq_addr;
  logic [31:0] o_zz_spc;
  logic [3:0]  o_irq_ack;

  always #5 clk = ~clk;

  irq_ctl dut (
    .i_clock     (clk),
    .i_rst_n     (rst_n),
    .i_pause     (pause),
    .i_irq_req   (req),
    .i_cur_pc    (cur_pc),
    .i_ret       (ret),
    .i_cfg_we    (we),
    .i_cfg_addr  (caddr),
    .i_cfg_wdata (wdata),
    .o_cfg_rdata (o_cfg_rdata),
    .o_pc_prectl (o_pc_prectl),
    .o_irq_addr  (o_irq_addr),
    .o_zz_spc    (o_zz_spc),
    .o_irq_ack   (o_irq_ack)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  typedef enum {M_RST, M_IDLE, M_TAKE, M_SERV} mphase_t;
  mphase_t     m_ph;
  logic        m_ien;
  logic [3:0]  m_mask, m_pend, m_ack;
  logic [31:0] m_vbase, m_addr, m_zz;
  int          m_k;
  // request line delayed by one and two edges, and the synchronised level
  // already accounted for by the edge detector
  logic [3:0]  m_d1, m_d2, m_seen;
  logic        prev_irq;

  function automatic void model_reset();
    m_ph = M_RST; m_ien = 1'b0; m_mask = '0; m_pend = '0; m_ack = '0;
    m_vbase = '0; m_addr = '0; m_zz = '0; m_k = 0;
    m_d1 = '0; m_d2 = '0; m_seen = '0;
  endfunction

  function automatic void model_edge();
    logic [3:0] old_d2, rise, elig, nxt_pend;
    logic       nxt_ien;
    int         k;
    old_d2 = m_d2;
    rise   = old_d2 & ~m_seen;
    m_d2   = m_d1;
    m_d1   = req;
    if (pause) return;
    m_seen   = old_d2;
    elig     = m_ien ? (m_pend & m_mask) : 4'b0;
    k        = -1;
    for (int i = 0; i < 4; i++) if (elig[i] && k < 0) k = i;
    nxt_pend = m_pend;
    nxt_ien  = m_ien;
    if (we && caddr == 2'd0) nxt_ien = wdata[0];
    if (we && caddr == 2'd2) nxt_pend = nxt_pend & ~wdata[3:0];
    case (m_ph)
      M_RST:  m_ph = M_IDLE;
      M_IDLE: if (k >= 0) begin
                m_addr = m_vbase + 32'(16 * k);
                m_ack  = 4'b0001 << k;
                m_k    = k;
                m_ph   = M_TAKE;
              end
      M_TAKE: begin
                m_zz = cur_pc;
                nxt_pend[m_k] = 1'b0;
                nxt_ien = 1'b0;
                m_ack = '0;
                m_ph = M_SERV;
              end
      M_SERV: if (ret) begin nxt_ien = 1'b1; m_ph = M_IDLE; end
      default: m_ph = M_RST;
    endcase
    m_pend = nxt_pend | rise;
    m_ien  = nxt_ien;
    if (we && caddr == 2'd1) m_mask = wdata[3:0];
    if (we && caddr == 2'd3) m_vbase = wdata & 32'hFFFF_FFC0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {31'b0, m_ien};
      2'd1:    return {28'b0, m_mask};
      2'd2:    return {28'b0, m_pend};
      default: return m_vbase;
    endcase
  endfunction

  function automatic logic [3:0] m_prectl();
    case (m_ph)
      M_RST:   return PC_RST;
      M_TAKE:  return PC_IRQ;
      default: return PC_IGN;
    endcase
  endfunction

  // ---------------- checking ----------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare();
    chk("prectl",   32'(o_pc_prectl), 32'(m_prectl()));
    chk("irq_addr", o_irq_addr, m_addr);
    chk("zz_spc",   o_zz_spc, m_zz);
    chk("irq_ack",  32'(o_irq_ack), 32'(m_ack));
    chk("cfg_rdata", o_cfg_rdata, m_read(caddr));
    if (o_pc_prectl == PC_IRQ && !prev_irq)
      $display("irq taken ack=%b vector=%h t=%0t", o_irq_ack, o_irq_addr, $time);
    prev_irq = (o_pc_prectl == PC_IRQ);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; caddr = a; wdata = d;
    tick();
    we = 1'b0;
    $display("cfg write addr=%0d data=%h", a, d);
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    caddr = a;
    #1;
    chk(name, o_cfg_rdata, exp);
    $display("cfg read addr=%0d data=%h", a, o_cfg_rdata);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_prectl", 32'(o_pc_prectl), 32'(PC_RST));
    chk("rst_zz_spc", o_zz_spc, 32'h0);
    chk("rst_irq_ack", 32'(o_irq_ack), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_prectl", 32'(o_pc_prectl), 32'(PC_RST));
    tick();
    chk("rel_prectl_ign", 32'(o_pc_prectl), 32'(PC_IGN));
    $display("reset applied and released t=%0t", $time);
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (n < max) begin
      tick();
      n++;
      if (o_pc_prectl == PC_IRQ) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_irq actual=no PC_IRQ within %0d cycles expected=PC_IRQ", max);
  endtask

  initial begin
    int n;
    int irq_cycles;
    prev_irq = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset release and all registers zero
    apply_reset();
    read_chk("ctrl0", 2'd0, 32'h0);
    read_chk("mask0", 2'd1, 32'h0);
    read_chk("pend0", 2'd2, 32'h0);
    read_chk("vbase0", 2'd3, 32'h0);

    // Single request on line 2
    cfg_wr(2'd3, 32'h0000_1000);
    cfg_wr(2'd1, 32'h4);
    cfg_wr(2'd0, 32'h1);
    cur_pc = 32'h0000_0230;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    wait_irq(10, n);
    chk("latency", 32'(n + 1), 32'd4);
    chk("vec2_addr", o_irq_addr, 32'h0000_1020);
    chk("vec2_ack", 32'(o_irq_ack), 32'h4);
    tick();
    chk("serv_ign", 32'(o_pc_prectl), 32'(PC_IGN));
    chk("zz_spc_230", o_zz_spc, 32'h0000_0230);
    read_chk("pend_cleared", 2'd2, 32'h0);
    read_chk("ien_cleared", 2'd0, 32'h0);

    // Lines 1 and 3 together while in service; priority after return
    cfg_wr(2'd1, 32'hF);
    req = 4'b1010;
    tick();
    req = 4'b0000;
    repeat (3) tick();
    read_chk("pend_a", 2'd2, 32'hA);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("ret_idle", 32'(o_pc_prectl), 32'(PC_IGN));
    tick();
    chk("take1", 32'(o_pc_prectl), 32'(PC_IRQ));
    chk("vec1_addr", o_irq_addr, 32'h0000_1010);
    chk("vec1_ack", 32'(o_irq_ack), 32'h2);
    tick();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("ret_idle2", 32'(o_pc_prectl), 32'(PC_IGN));
    tick();
    chk("take3", 32'(o_pc_prectl), 32'(PC_IRQ));
    chk("vec3_addr", o_irq_addr, 32'h0000_1030);
    chk("vec3_ack", 32'(o_irq_ack), 32'h8);
    tick();
    ret = 1'b1;
    tick();
    ret = 1'b0;

    // Masked line 0: pends but is never taken; W1C; edge beats clear
    cfg_wr(2'd1, 32'h4);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    irq_cycles = 0;
    repeat (6) begin
      tick();
      if (o_pc_prectl == PC_IRQ) irq_cycles++;
    end
    chk("masked_no_irq", 32'(irq_cycles), 32'd0);
    read_chk("pend_masked", 2'd2, 32'h1);
    cfg_wr(2'd2, 32'h1);
    read_chk("pend_w1c", 2'd2, 32'h0);
    req = 4'b0001;
    tick();
    tick();
    cfg_wr(2'd2, 32'h1);
    read_chk("set_beats_clear", 2'd2, 32'h1);
    req = 4'b0000;
    cfg_wr(2'd2, 32'h1);
    read_chk("pend_w1c2", 2'd2, 32'h0);

    // Pause held during TAKE
    cur_pc = 32'h0000_0600;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    wait_irq(10, n);
    irq_cycles = 1;
    pause = 1'b1;
    repeat (3) begin
      tick();
      if (o_pc_prectl == PC_IRQ && o_irq_ack == 4'b0100) irq_cycles++;
    end
    pause = 1'b0;
    cur_pc = 32'h0000_0700;
    tick();
    chk("pause_irq_cycles", 32'(irq_cycles), 32'd4);
    chk("pause_zz_once", o_zz_spc, 32'h0000_0700);
    chk("pause_ack_off", 32'(o_irq_ack), 32'h0);
    cur_pc = 32'h0000_0800;
    tick();
    chk("zz_held", o_zz_spc, 32'h0000_0700);

    // Reset while in service
    apply_reset();

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      pause  = ($urandom_range(0, 4) == 0);
      ret    = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      cur_pc = $urandom;
      we     = ($urandom_range(0, 11) == 0);
      caddr  = 2'($urandom_range(0, 3));
      wdata  = $urandom;
      if (caddr == 2'd0 && $urandom_range(0, 4) != 0) wdata[0] = 1'b1;
      if ($urandom_range(0, 999) == 0) apply_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctl.md
# irq_ctl

Interrupt controller for the mips789 core: the responder side of the `pc_gen` pre-control interface. It synchronises and latches four external request lines, arbitrates them against a mask and global enable, and drives `pc_prectl` and the vector address into `pc_gen`. It saves the resume PC as `zz_spc` and reopens interrupts when the pipeline signals a return (`PC_RET`). It sits beside `pc_gen` in the fetch stage. A small configuration port makes it software-visible.

## Interface
- `NIRQ`, 4: number of request lines (fixed at 4; index width 2).
- `clock` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pause` in 1: pipeline stall; while high, all state and outputs hold (synchronisers still run).
- `irq_req` in 4: asynchronous request lines; a rising edge requests service.
- `cur_pc` in 32: PC of the next instruction to execute, valid every non-paused cycle.
- `ret` in 1: the decoded instruction is a return (`ctl == PC_RET`); one-cycle pulse.
- `cfg_we` in 1, `cfg_addr` in 2, `cfg_wdata` in 32: register write port.
- `cfg_rdata` out 32: combinational read of the register at `cfg_addr`.
- `pc_prectl` out 4: `PC_RST`, `PC_IGN`, `PC_IRQ` (encodings from `mips789_defs.v`).
- `irq_addr` out 32: vector address to `pc_gen.irq`.
- `zz_spc` out 32: saved return PC to `pc_gen.zz_spc`.
- `irq_ack` out 4: one-hot, high for the single cycle `PC_IRQ` is driven.

## Operation
- Registers:
  - 0 CTRL: bit0 `ien` (global enable).
  - 1 MASK: bits[3:0], 1 = enabled.
  - 2 PEND: read gives pending bits; write-1-to-clear.
  - 3 VBASE: bits[31:6]; bits[5:0] read 0.
  - Unused bits read 0.
- Request path: 2-FF synchroniser per line, plus a third stage for edge detect. A rising edge (`s2 & ~s3`) sets `pend[i]`. A set on the same cycle as a W1C clear or an ack of that bit wins.
- Eligible = `pend & mask`, gated by `ien`. Priority: lowest index wins.
- FSM states:
  - RST: entered on reset. Drives `PC_RST` while `rst_n` is low and for one cycle after release, then goes to IDLE.
  - IDLE: drives `PC_IGN`. If any eligible bit, goes to TAKE next edge.
  - TAKE: drives `PC_IRQ` and `irq_ack[k]` for one non-paused cycle. At that edge:
    - `zz_spc <= cur_pc`
    - `irq_addr <= {vbase[31:6], k[1:0], 4'b0}`, latched on entry to TAKE
    - `pend[k]` cleared
    - `ien` cleared
    - next state SERV.
  - SERV: drives `PC_IGN`. New edges still latch into `pend`, but none is taken. On `ret`: `ien <= 1`, next state IDLE.
- `ret` outside SERV is ignored.
- A config write to CTRL in SERV updates `ien`, but has no effect on FSM arbitration until IDLE.

## Timing
- Reset values:
  - `pc_prectl` = `PC_RST`
  - `irq_addr`, `zz_spc`, `irq_ack`, `cfg_rdata` bits = 0
  - `ien`, `mask`, `pend`, `vbase` = 0
- All outputs except `cfg_rdata` are registered.
- Request latency: `irq_req` high before edge N → `pend` set after edge N+2 → TAKE after N+3 → `PC_IRQ` visible in cycle N+3..N+4. That is 4 edges to vector fetch with no pause.
- `pause` high in TAKE extends `PC_IRQ`/`irq_ack` until the first non-paused edge. It is counted once: one ack, one `zz_spc` capture.
- `ret` and a new eligible request in the same cycle: go to IDLE first; TAKE follows one cycle later (one IDLE cycle is guaranteed).
- A config write is visible to arbitration on the edge after the write.
- Reset mid-TAKE or mid-SERV: immediate return to RST; the pending request is lost.

## Structure
- Add to `mips789_defs.v`:
  - `IRQ_CTRL`, `IRQ_MASK`, `IRQ_PEND`, `IRQ_VBASE` address constants.
  - FSM state encodings `IRQ_S_RST/IDLE/TAKE/SERV`.
  - The existing `PC_*` pre-control codes are reused.
- One sub-module: `irq_sync`, a per-line 3-FF synchroniser and rising-edge detector. Instantiate it 4×.

## Test plan
- Reset release → `pc_prectl` = `PC_RST` for exactly 1 cycle, then `PC_IGN`; all registers read 0.
- VBASE=0x0000_1000, MASK=0x4, `ien`=1, `cur_pc`=0x0000_0230, pulse `irq_req[2]` → after 4 edges: `PC_IRQ` for 1 cycle, `irq_addr`=0x0000_1020, `irq_ack`=0100, `zz_spc`=0x0000_0230, PEND=0, `ien`=0.
- `irq_req[1]` and `irq_req[3]` rise together, MASK=0xF → line 1 taken. `ret` → 1 IDLE cycle, then line 3 taken with `irq_addr`=VBASE+0x30.
- Request on masked line 0 → PEND=0x1, no `PC_IRQ`; write PEND=0x1 → PEND=0; the same-cycle edge set wins over the clear.
- `pause` held 3 cycles during TAKE → `PC_IRQ` held 4 cycles, one `irq_ack` sampled edge, `zz_spc` captured once.
- Assert `rst_n` low in SERV → `pc_prectl`=`PC_RST` asynchronously, `zz_spc`=0.
